// File: rtl/control_seq.sv
// Instruction sequencer: fetches opcodes into IR and steps the datapath control lines.
// Latency: FETCH plus 1 exec step (LDI 2 steps); HALT parks in HALTED until reset.
// Backpressure: run=0 stalls only at FETCH; an instruction already fetched always completes.
module control_seq #(
   parameter logic ALU_OP_HIGH = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] mem_in,
   output logic [3:0] gp_assert_main,
   output logic [3:0] gp_load_main,
   output logic [3:0] gp_assert_lhs,
   output logic [3:0] gp_assert_rhs,
   output logic       const_load_mem,
   output logic       const_assert_main,
   output logic       pcra0_assert_addr,
   output logic       pcra0_inc,
   output logic       si_assert_addr,
   output logic       di_assert_addr,
   output logic       mem_dir,
   output logic       mem_assert_main,
   output logic       mem_load_main,
   output logic       alu_assert_main,
   output logic [3:0] alu_operation,
   output logic [7:0] ir,
   output logic       halted,
   output logic       illegal_op
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC0  = 2'd1,
      S_EXEC1  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;

   // Opcode classes decoded from the registered instruction only
   logic is_nop, is_ldi, is_ld, is_st, is_mov, is_alu, is_halt, is_illegal;

   assign is_nop     = (ir_q == 8'h00);
   assign is_ldi     = (ir_q[7:2] == 6'b000001);
   assign is_ld      = (ir_q[7:2] == 6'b000010);
   assign is_st      = (ir_q[7:2] == 6'b000011);
   assign is_mov     = (ir_q[7:4] == 4'b0101);
   assign is_alu     = ir_q[7];
   assign is_halt    = (ir_q == 8'h3F);
   assign is_illegal = !(is_nop || is_ldi || is_ld || is_st || is_mov || is_alu || is_halt);

   function automatic logic [3:0] sel4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // State and instruction register; reset abandons any instruction in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state: fetch when permitted, LDI takes a second step, HALT parks
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            if (run) begin
               ir_d    = mem_in;
               state_d = S_EXEC0;
            end
         end
         S_EXEC0: begin
            if (is_ldi)       state_d = S_EXEC1;
            else if (is_halt) state_d = S_HALTED;
            else              state_d = S_FETCH;
         end
         S_EXEC1:  state_d = S_FETCH;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_FETCH;
      endcase
   end

   // Control outputs from registered state/IR; reset low forces everything to zero
   always_comb begin
      gp_assert_main    = '0;
      gp_load_main      = '0;
      gp_assert_lhs     = '0;
      gp_assert_rhs     = '0;
      const_load_mem    = 1'b0;
      const_assert_main = 1'b0;
      pcra0_assert_addr = 1'b0;
      pcra0_inc         = 1'b0;
      si_assert_addr    = 1'b0;
      di_assert_addr    = 1'b0;
      mem_dir           = 1'b0;
      mem_assert_main   = 1'b0;
      mem_load_main     = 1'b0;
      alu_assert_main   = 1'b0;
      alu_operation     = '0;
      ir                = '0;
      halted            = 1'b0;
      illegal_op        = 1'b0;
      if (reset) begin
         ir = ir_q;
         case (state_q)
            S_FETCH: begin
               if (run) begin
                  pcra0_assert_addr = 1'b1;
                  mem_dir           = 1'b1;
                  pcra0_inc         = 1'b1;
               end
            end
            S_EXEC0: begin
               if (is_ldi) begin
                  // Immediate byte sits at the next PC; latch it straight off the memory bus
                  pcra0_assert_addr = 1'b1;
                  mem_dir           = 1'b1;
                  const_load_mem    = 1'b1;
                  pcra0_inc         = 1'b1;
               end else if (is_ld) begin
                  si_assert_addr  = 1'b1;
                  mem_dir         = 1'b1;
                  mem_assert_main = 1'b1;
                  gp_load_main    = sel4(ir_q[1:0]);
               end else if (is_st) begin
                  di_assert_addr = 1'b1;
                  mem_dir        = 1'b0;
                  gp_assert_main = sel4(ir_q[1:0]);
                  mem_load_main  = 1'b1;
               end else if (is_mov) begin
                  gp_assert_main = sel4(ir_q[1:0]);
                  gp_load_main   = sel4(ir_q[3:2]);
               end else if (is_alu) begin
                  // Result is written back to the lhs register
                  gp_assert_lhs   = sel4(ir_q[3:2]);
                  gp_assert_rhs   = sel4(ir_q[1:0]);
                  alu_operation   = {ALU_OP_HIGH, ir_q[6:4]};
                  alu_assert_main = 1'b1;
                  gp_load_main    = sel4(ir_q[3:2]);
               end else if (is_illegal) begin
                  illegal_op = 1'b1;
               end
            end
            S_EXEC1: begin
               const_assert_main = 1'b1;
               gp_load_main      = sel4(ir_q[1:0]);
            end
            S_HALTED: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: directed program walk, then randomized run/reset/memory traffic.
// Latency: one check per clock at the falling edge against a step-queue reference model.
// Backpressure: run is driven per cycle; stalls are modelled only at instruction boundaries.
module tb_control_seq;

   typedef struct packed {
      logic [3:0] gp_assert_main;
      logic [3:0] gp_load_main;
      logic [3:0] gp_assert_lhs;
      logic [3:0] gp_assert_rhs;
      logic       const_load_mem;
      logic       const_assert_main;
      logic       pcra0_assert_addr;
      logic       pcra0_inc;
      logic       si_assert_addr;
      logic       di_assert_addr;
      logic       mem_dir;
      logic       mem_assert_main;
      logic       mem_load_main;
      logic       alu_assert_main;
      logic [3:0] alu_operation;
      logic       halted;
      logic       illegal_op;
   } ctrl_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [7:0] mem_in = 8'h00;
   logic [3:0] gp_assert_main, gp_load_main, gp_assert_lhs, gp_assert_rhs;
   logic       const_load_mem, const_assert_main, pcra0_assert_addr, pcra0_inc;
   logic       si_assert_addr, di_assert_addr, mem_dir, mem_assert_main, mem_load_main;
   logic       alu_assert_main, halted, illegal_op;
   logic [3:0] alu_operation;
   logic [7:0] ir;
   ctrl_t      obs;

   control_seq #(.ALU_OP_HIGH(1'b0)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_in(mem_in),
      .gp_assert_main(gp_assert_main), .gp_load_main(gp_load_main),
      .gp_assert_lhs(gp_assert_lhs), .gp_assert_rhs(gp_assert_rhs),
      .const_load_mem(const_load_mem), .const_assert_main(const_assert_main),
      .pcra0_assert_addr(pcra0_assert_addr), .pcra0_inc(pcra0_inc),
      .si_assert_addr(si_assert_addr), .di_assert_addr(di_assert_addr),
      .mem_dir(mem_dir), .mem_assert_main(mem_assert_main), .mem_load_main(mem_load_main),
      .alu_assert_main(alu_assert_main), .alu_operation(alu_operation),
      .ir(ir), .halted(halted), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign obs = {gp_assert_main, gp_load_main, gp_assert_lhs, gp_assert_rhs,
                 const_load_mem, const_assert_main, pcra0_assert_addr, pcra0_inc,
                 si_assert_addr, di_assert_addr, mem_dir, mem_assert_main, mem_load_main,
                 alu_assert_main, alu_operation, halted, illegal_op};

   // Reference model: remaining exec steps of the current instruction, plus program memory
   ctrl_t      q[$];
   logic [7:0] m_ir = 8'h00;
   bit         m_halt = 1'b0;
   logic [7:0] mem [256];
   int         pc = 0;
   int         n_asrt = 0;
   int         n_fail = 0;
   ctrl_t      snap;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] ex);
      n_asrt++;
      assert (o === ex) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, ex);
      end
   endtask

   // Expand an opcode into the list of control words its exec steps must show
   task automatic expand(input logic [7:0] op);
      int    v, r0, r1, alu;
      ctrl_t s;
      v   = int'(op);
      r0  = v % 4;
      r1  = (v / 4) % 4;
      alu = (v / 16) % 8;
      s   = '0;
      if (v == 0 || v == 8'h3F) begin
         q.push_back(s);
      end else if (v >= 4 && v < 8) begin
         s.pcra0_assert_addr = 1'b1; s.mem_dir = 1'b1;
         s.const_load_mem = 1'b1;    s.pcra0_inc = 1'b1;
         q.push_back(s);
         s = '0;
         s.const_assert_main = 1'b1;
         s.gp_load_main = 4'(1 << r0);
         q.push_back(s);
      end else if (v >= 8 && v < 12) begin
         s.si_assert_addr = 1'b1; s.mem_dir = 1'b1; s.mem_assert_main = 1'b1;
         s.gp_load_main = 4'(1 << r0);
         q.push_back(s);
      end else if (v >= 12 && v < 16) begin
         s.di_assert_addr = 1'b1; s.mem_load_main = 1'b1;
         s.gp_assert_main = 4'(1 << r0);
         q.push_back(s);
      end else if (v >= 8'h50 && v < 8'h60) begin
         s.gp_assert_main = 4'(1 << r0);
         s.gp_load_main   = 4'(1 << r1);
         q.push_back(s);
      end else if (v >= 128) begin
         s.gp_assert_lhs   = 4'(1 << r1);
         s.gp_assert_rhs   = 4'(1 << r0);
         s.gp_load_main    = 4'(1 << r1);
         s.alu_operation   = 4'(alu);
         s.alu_assert_main = 1'b1;
         q.push_back(s);
      end else begin
         s.illegal_op = 1'b1;
         q.push_back(s);
      end
   endtask

   // One clock: drive inputs, check at the falling edge, advance the model after the rise
   task automatic step(input bit r, input bit rstn, input string tag, output ctrl_t o);
      ctrl_t      e;
      logic [7:0] bus;
      bus    = mem[pc];
      reset  = rstn;
      run    = r;
      mem_in = bus;
      e = '0;
      if (!rstn)             e = '0;
      else if (m_halt)       e.halted = 1'b1;
      else if (q.size() > 0) e = q[0];
      else if (r) begin
         e.pcra0_assert_addr = 1'b1; e.mem_dir = 1'b1; e.pcra0_inc = 1'b1;
      end
      @(negedge clk);
      o = obs;
      check({tag, "_ctrl"}, 32'(obs), 32'(e));
      check({tag, "_ir"}, 32'(ir), rstn ? 32'(m_ir) : 32'h0);
      @(posedge clk);
      #1;
      if (!rstn) begin
         q.delete();
         m_halt = 1'b0;
         m_ir   = 8'h00;
      end else if (!m_halt) begin
         if (q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() == 0 && m_ir == 8'h3F) m_halt = 1'b1;
         end else if (r) begin
            m_ir = bus;
            expand(bus);
         end
      end
      if (e.pcra0_inc) pc = (pc + 1) % 256;
   endtask

   initial begin
      int drivers;
      bit rr, rs;
      for (int i = 0; i < 256; i++) mem[i] = 8'h04;

      // Reset held low with run high and an LDI on the bus
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset", snap);
      check("reset_zero", 32'(snap), 32'h0);

      mem[0] = 8'h05; mem[1] = 8'h5A; mem[2] = 8'h5E; mem[3] = 8'h96;
      mem[4] = 8'h0A; mem[5] = 8'h0F; mem[6] = 8'h20; mem[7] = 8'h00;
      mem[8] = 8'h3F;
      pc = 0;

      step(1'b1, 1'b1, "fetch_ldi", snap);
      check("first_fetch", {29'h0, snap.pcra0_assert_addr, snap.pcra0_inc, snap.mem_dir}, 32'h7);
      step(1'b1, 1'b1, "ldi_e0", snap);
      check("ldi_e0_lit", {30'h0, snap.const_load_mem, snap.pcra0_inc}, 32'h3);
      step(1'b1, 1'b1, "ldi_e1", snap);
      check("ldi_e1_lit", {27'h0, snap.const_assert_main, snap.gp_load_main}, 32'h12);
      step(1'b1, 1'b1, "fetch_mov", snap);
      check("ldi_next_fetch", 32'(snap.pcra0_assert_addr), 32'h1);
      step(1'b1, 1'b1, "mov", snap);
      check("mov_lit", {24'h0, snap.gp_assert_main, snap.gp_load_main}, 32'h48);
      step(1'b1, 1'b1, "fetch_alu", snap);
      step(1'b1, 1'b1, "alu", snap);
      check("alu_lit", {16'h0, snap.gp_assert_lhs, snap.gp_assert_rhs, snap.alu_operation,
                        snap.gp_load_main}, 32'h2412);
      step(1'b1, 1'b1, "fetch_ld", snap);
      step(1'b1, 1'b1, "ld", snap);
      check("ld_lit", {25'h0, snap.si_assert_addr, snap.mem_dir, snap.mem_assert_main,
                       snap.gp_load_main}, 32'h74);
      step(1'b1, 1'b1, "fetch_st", snap);
      step(1'b1, 1'b1, "st", snap);
      check("st_lit", {25'h0, snap.di_assert_addr, snap.mem_dir, snap.mem_load_main,
                       snap.gp_assert_main}, 32'h58);
      step(1'b1, 1'b1, "fetch_ill", snap);
      step(1'b1, 1'b1, "illegal", snap);
      check("illegal_lit", 32'(snap), 32'h1);
      step(1'b1, 1'b1, "fetch_nop", snap);
      check("illegal_pulse_end", 32'(snap.illegal_op), 32'h0);
      step(1'b1, 1'b1, "nop", snap);
      step(1'b1, 1'b1, "fetch_halt", snap);
      step(1'b1, 1'b1, "halt_e0", snap);
      for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b1, "halted", snap);
      check("halted_lit", 32'(snap), 32'h2);
      step(1'b1, 1'b0, "halt_reset", snap);

      // run dropped during LDI EXEC0: instruction still finishes, then fetch idles
      pc = 0; mem[0] = 8'h04; mem[1] = 8'h77; mem[2] = 8'h00;
      step(1'b1, 1'b1, "stall_fetch", snap);
      step(1'b0, 1'b1, "stall_e0", snap);
      check("stall_e0_lit", 32'(snap.const_load_mem), 32'h1);
      step(1'b0, 1'b1, "stall_e1", snap);
      check("stall_e1_lit", {27'h0, snap.const_assert_main, snap.gp_load_main}, 32'h11);
      step(1'b0, 1'b1, "stall_idle0", snap);
      check("stall_idle_lit", 32'(snap), 32'h0);
      step(1'b0, 1'b1, "stall_idle1", snap);
      step(1'b1, 1'b1, "resume", snap);
      check("resume_lit", 32'(snap.pcra0_assert_addr), 32'h1);

      // Randomized traffic with occasional HALT bytes and resets
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 40) == 0) ? 8'h3F : 8'($urandom_range(0, 255));
      for (int c = 0; c < 3000; c++) begin
         rr = ($urandom_range(0, 3) != 0);
         rs = m_halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 63) != 0);
         step(rr, rs, "rand", snap);
         drivers = int'(snap.gp_assert_main != 4'h0) + int'(snap.const_assert_main)
                 + int'(snap.mem_assert_main) + int'(snap.alu_assert_main);
         check("inv_one_driver", 32'(drivers <= 1), 32'h1);
         check("inv_mem_dir", 32'(snap.mem_assert_main && snap.mem_load_main), 32'h0);
         check("inv_gp_onehot", 32'($countones(snap.gp_assert_main) <= 1 &&
                                    $countones(snap.gp_load_main) <= 1), 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
